output_port_allocator: RTL

- Per-output-port packet scheduler for the 5-port router (L, N, E, W, S).
- Arbitrates head flits from the five input ports using round-robin priority.
- Locks the output to the winner until its tail flit has been forwarded.
- Gates forwarding on a downstream credit counter, so the output buffer never overflows.

---
 rtl/arbiter_pkg.sv | 22 ++
 rtl/rr_pick.sv | 30 +++
 rtl/output_port_allocator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared definitions for the router's output-port allocators: requester
// ordering, flit-type bit positions and the allocator state encoding.
package arbiter_pkg;

   localparam int NREQ = 5;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_S = 4;

   localparam int FLIT_HEAD_BIT = 0;
   localparam int FLIT_BODY_BIT = 1;
   localparam int FLIT_TAIL_BIT = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches upward from the slot after
// rr_ptr (wrapping) and returns the first eligible requester as a one-hot
// vector. Shared by every allocator in the router.
module rr_pick #(
   parameter int N  = arbiter_pkg::NREQ,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [PW-1:0] rr_ptr,
   output logic [N-1:0]  winner,
   output logic          any_valid
);
   import arbiter_pkg::*;

   // first eligible requester in order rr_ptr+1, rr_ptr+2, ... modulo N
   always_comb begin
      int idx;
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(rr_ptr) + k) % N;
         if (!any_valid && eligible[idx]) begin
            winner[idx] = 1'b1;
            any_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port packet scheduler for the 5-port router. Grants the port
// to one input by round-robin, holds it until the tail flit leaves, and
// gates every transfer on the downstream credit count.
// Optional build macro WATCHDOG_EN: releases a lock whose owner has not
// forwarded for TIMEOUT cycles and pulses timeout_err.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | port free; arbitrate head flits, never forward
// LOCKED | port owned by grant; forward owner flits while credits last
module output_port_allocator #(
   parameter int NREQ    = arbiter_pkg::NREQ,
   parameter int CREDITS = 4,
   parameter int CW      = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] flit_id,
   input  logic              credit_in,
   output logic [NREQ-1:0]   grant,
   output logic              fwd,
   output logic [CW-1:0]     credits,
   output logic              timeout_err
);
   import arbiter_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef WATCHDOG_EN
   localparam int WD_RAW = $clog2(TIMEOUT + 1);
   localparam int WD_W   = (WD_RAW < 10) ? 10 : WD_RAW;

   // down-counter: reloaded with TIMEOUT, release when it reaches zero
   logic [WD_W-1:0] wd_cnt;
`endif

   alloc_state_t    state;
   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] winner;
   logic            any_valid;
   logic [PW-1:0]   owner_idx;
   logic            owner_req;
   logic            owner_tail;

   // only head flits compete for a free port
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req[i] & flit_id[3*i + FLIT_HEAD_BIT];
      end
   end

   rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_rr_pick (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // decode the current owner from the one-hot grant
   always_comb begin
      owner_idx  = '0;
      owner_req  = 1'b0;
      owner_tail = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            owner_idx  = PW'(i);
            owner_req  = req[i];
            owner_tail = flit_id[3*i + FLIT_TAIL_BIT];
         end
      end
   end

   assign fwd = (state == LOCKED) && owner_req && (credits != '0);

   // credit counter: +1 per returned slot, -1 per forwarded flit, saturating at CREDITS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits <= CW'(CREDITS);
      end else begin
         case ({credit_in, fwd})
            2'b10: if (credits != CW'(CREDITS)) credits <= credits + 1'b1;
            2'b01: credits <= credits - 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   // allocation FSM: arbitrate in IDLE, hold the lock until tail (or watchdog) in LOCKED
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= PW'(NREQ - 1);
`ifdef WATCHDOG_EN
         wd_cnt      <= WD_W'(TIMEOUT);
         timeout_err <= 1'b0;
`endif
      end else begin
`ifdef WATCHDOG_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef WATCHDOG_EN
               wd_cnt <= WD_W'(TIMEOUT);
`endif
               if (any_valid) begin
                  grant <= winner;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (fwd && owner_tail) begin
                  state  <= IDLE;
                  grant  <= '0;
                  rr_ptr <= owner_idx;
               end
`ifdef WATCHDOG_EN
               // a transfer this cycle always wins over an expiring timer
               if (fwd) begin
                  wd_cnt <= WD_W'(TIMEOUT);
               end else if (wd_cnt == '0) begin
                  state       <= IDLE;
                  grant       <= '0;
                  rr_ptr      <= owner_idx;
                  timeout_err <= 1'b1;
                  wd_cnt      <= WD_W'(TIMEOUT);
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
`endif
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

`ifndef WATCHDOG_EN
   assign timeout_err = 1'b0;
`endif

endmodule
